// File: rtl/fft_r2_ctrl_param.sv
// Control sequencer for an in-place radix-2 DIF FFT over two dual-port SRAM banks.
// Sample i lives in bank parity(i) at address i>>1, so butterfly partners always
// sit in opposite banks. Sequence: LOAD (N) -> LOG2N x (STAGE N/2 + GAP WLAT) ->
// UNLOAD (N bit-reversed reads + 1 drain cycle). valid=0 freezes everything.
module fft_r2_ctrl_param #(
    parameter  int LOG2N = 6,
    parameter  int WLAT  = 2,
    localparam int AW    = LOG2N - 1
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          start,
    input  logic          valid,
    output logic          busy,
    output logic          input_done,
    output logic [3:0]    stage,
    output logic          swap0_en,
    output logic          swap1_en,
    output logic          we_b0,
    output logic          re_b0,
    output logic          we_b1,
    output logic          re_b1,
    output logic [AW-1:0] waddr_b0,
    output logic [AW-1:0] raddr_b0,
    output logic [AW-1:0] waddr_b1,
    output logic [AW-1:0] raddr_b1,
    output logic          out_valid,
    output logic          out_bank,
    output logic          done
);

    localparam int N  = 1 << LOG2N;
    localparam int CW = LOG2N + 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_STAGE  = 3'd2;
    localparam logic [2:0] ST_GAP    = 3'd3;
    localparam logic [2:0] ST_UNLOAD = 3'd4;

    localparam logic [CW-1:0] LOAD_LAST  = CW'(N - 1);
    localparam logic [CW-1:0] STAGE_LAST = CW'(N / 2 - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(WLAT - 1);
    localparam logic [CW-1:0] UNL_LAST   = CW'(N);
    localparam logic [3:0]    S_LAST     = 4'(LOG2N - 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    stg_q, stg_d;

    // Issue-side decode (combinational from state/counter)
    logic [LOG2N-1:0] idx, top, bot, mask, unl_i;
    logic [3:0]       p;
    logic             ld_we0, ld_we1;
    logic [AW-1:0]    ld_addr;
    logic             rd_en, rd_flag;
    logic [AW-1:0]    rd_a0, rd_a1;
    logic             unl_re, unl_bank;
    logic [AW-1:0]    unl_addr;

    // Write-back delay line (WLAT valid cycles) and 1-cycle read-data alignment
    logic [WLAT-1:0]         dl_we_q, dl_sw_q;
    logic [WLAT-1:0][AW-1:0] dl_a0_q, dl_a1_q;
    logic                    sw0_q, ov_q, ob_q, last_q;

    // FSM and counter next-state; nothing moves without valid
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stg_d   = stg_q;
        if (valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_LOAD;
                        cnt_d   = '0;
                        stg_d   = '0;
                    end
                end
                ST_LOAD: begin
                    if (cnt_q == LOAD_LAST) begin
                        state_d = ST_STAGE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_STAGE: begin
                    if (cnt_q == STAGE_LAST) begin
                        state_d = ST_GAP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d = '0;
                        if (stg_q == S_LAST) begin
                            state_d = ST_UNLOAD;
                        end else begin
                            state_d = ST_STAGE;
                            stg_d   = stg_q + 4'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_UNLOAD: begin
                    // Extra cycle at cnt=N lets the last read's data emerge before IDLE
                    if (cnt_q == UNL_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    stg_d   = '0;
                end
            endcase
        end
    end

    // Address and enable generation for load, butterfly reads and unload
    always_comb begin
        ld_we0   = 1'b0;
        ld_we1   = 1'b0;
        ld_addr  = '0;
        rd_en    = 1'b0;
        rd_flag  = 1'b0;
        rd_a0    = '0;
        rd_a1    = '0;
        unl_re   = 1'b0;
        unl_bank = 1'b0;
        unl_addr = '0;
        idx      = cnt_q[LOG2N-1:0];
        p        = S_LAST - stg_q;
        mask     = (LOG2N'(1) << p) - LOG2N'(1);
        // top = pair index j with a zero inserted at bit p
        top      = (({1'b0, idx[AW-1:0]} & ~mask) << 1) | ({1'b0, idx[AW-1:0]} & mask);
        bot      = top | (LOG2N'(1) << p);
        unl_i    = '0;
        for (int unsigned b = 0; b < LOG2N; b++) begin
            unl_i[b] = idx[LOG2N-1-b];
        end
        case (state_q)
            ST_LOAD: begin
                ld_we0  = ~^idx;
                ld_we1  = ^idx;
                ld_addr = AW'(idx >> 1);
            end
            ST_STAGE: begin
                rd_en   = 1'b1;
                rd_flag = ^top;
                if (rd_flag) begin
                    rd_a0 = AW'(bot >> 1);
                    rd_a1 = AW'(top >> 1);
                end else begin
                    rd_a0 = AW'(top >> 1);
                    rd_a1 = AW'(bot >> 1);
                end
            end
            ST_UNLOAD: begin
                if (cnt_q != UNL_LAST) begin
                    unl_re   = 1'b1;
                    unl_bank = ^unl_i;
                    unl_addr = AW'(unl_i >> 1);
                end
            end
            default: ;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            stg_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stg_q   <= stg_d;
        end
    end

    // Delay lines advance in valid cycles only; reset drops any pending write
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            dl_we_q <= '0;
            dl_sw_q <= '0;
            dl_a0_q <= '0;
            dl_a1_q <= '0;
            sw0_q   <= 1'b0;
            ov_q    <= 1'b0;
            ob_q    <= 1'b0;
            last_q  <= 1'b0;
        end else if (valid) begin
            for (int unsigned k = 1; k < WLAT; k++) begin
                dl_we_q[k] <= dl_we_q[k-1];
                dl_sw_q[k] <= dl_sw_q[k-1];
                dl_a0_q[k] <= dl_a0_q[k-1];
                dl_a1_q[k] <= dl_a1_q[k-1];
            end
            dl_we_q[0] <= rd_en;
            dl_sw_q[0] <= rd_flag;
            dl_a0_q[0] <= rd_a0;
            dl_a1_q[0] <= rd_a1;
            sw0_q      <= rd_flag;
            ov_q       <= unl_re;
            ob_q       <= unl_bank;
            last_q     <= unl_re && (cnt_q == LOAD_LAST);
        end
    end

    // Output assembly; enables are gated so valid=0 is a clean bubble
    always_comb begin
        busy       = (state_q != ST_IDLE);
        input_done = (state_q == ST_STAGE) || (state_q == ST_GAP) || (state_q == ST_UNLOAD);
        stage      = (state_q == ST_STAGE) ? stg_q : 4'd0;
        swap0_en   = sw0_q;
        swap1_en   = dl_sw_q[WLAT-1];
        we_b0      = valid & (ld_we0 | dl_we_q[WLAT-1]);
        we_b1      = valid & (ld_we1 | dl_we_q[WLAT-1]);
        re_b0      = valid & (rd_en | (unl_re & ~unl_bank));
        re_b1      = valid & (rd_en | (unl_re & unl_bank));
        waddr_b0   = dl_we_q[WLAT-1] ? dl_a0_q[WLAT-1] : (ld_we0 ? ld_addr : '0);
        waddr_b1   = dl_we_q[WLAT-1] ? dl_a1_q[WLAT-1] : (ld_we1 ? ld_addr : '0);
        raddr_b0   = rd_en ? rd_a0 : ((unl_re & ~unl_bank) ? unl_addr : '0);
        raddr_b1   = rd_en ? rd_a1 : ((unl_re & unl_bank) ? unl_addr : '0);
        out_valid  = valid & ov_q;
        out_bank   = ob_q;
        done       = valid & ov_q & last_q;
    end

endmodule

// File: tb/tb_fft_r2_ctrl_param.sv
// Scoreboard bench: stimulus pushes hand-computed events (with expected frame
// cycle index counted in valid cycles) into queues; monitors pop and compare.
module tb_fft_r2_ctrl_param;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    // DUT A: LOG2N=3, WLAT=2
    logic start_a, valid_a;
    logic busy_a, input_done_a, swap0_en_a, swap1_en_a;
    logic [3:0] stage_a;
    logic we_b0_a, re_b0_a, we_b1_a, re_b1_a;
    logic [1:0] waddr_b0_a, raddr_b0_a, waddr_b1_a, raddr_b1_a;
    logic out_valid_a, out_bank_a, done_a;

    // DUT B: LOG2N=6, WLAT=4
    logic start_b, valid_b;
    logic busy_b, input_done_b, swap0_en_b, swap1_en_b;
    logic [3:0] stage_b;
    logic we_b0_b, re_b0_b, we_b1_b, re_b1_b;
    logic [4:0] waddr_b0_b, raddr_b0_b, waddr_b1_b, raddr_b1_b;
    logic out_valid_b, out_bank_b, done_b;

    fft_r2_ctrl_param #(.LOG2N(3), .WLAT(2)) u_a (
        .clk(clk), .nrst(nrst), .start(start_a), .valid(valid_a),
        .busy(busy_a), .input_done(input_done_a), .stage(stage_a),
        .swap0_en(swap0_en_a), .swap1_en(swap1_en_a),
        .we_b0(we_b0_a), .re_b0(re_b0_a), .we_b1(we_b1_a), .re_b1(re_b1_a),
        .waddr_b0(waddr_b0_a), .raddr_b0(raddr_b0_a),
        .waddr_b1(waddr_b1_a), .raddr_b1(raddr_b1_a),
        .out_valid(out_valid_a), .out_bank(out_bank_a), .done(done_a)
    );

    fft_r2_ctrl_param #(.LOG2N(6), .WLAT(4)) u_b (
        .clk(clk), .nrst(nrst), .start(start_b), .valid(valid_b),
        .busy(busy_b), .input_done(input_done_b), .stage(stage_b),
        .swap0_en(swap0_en_b), .swap1_en(swap1_en_b),
        .we_b0(we_b0_b), .re_b0(re_b0_b), .we_b1(we_b1_b), .re_b1(re_b1_b),
        .waddr_b0(waddr_b0_b), .raddr_b0(raddr_b0_b),
        .waddr_b1(waddr_b1_b), .raddr_b1(raddr_b1_b),
        .out_valid(out_valid_b), .out_bank(out_bank_b), .done(done_b)
    );

    typedef struct {
        int t;
        int bank;
        int a0;
        int a1;
        int flag;
        int stg;
    } ev_t;

    ev_t q_ld[$], q_rd[$], q_wb[$], q_unl[$], q_out[$], q_wb_b[$];

    int n_checks = 0;
    int n_errors = 0;

    // Hand-computed N=8 tables: sample i -> bank parity(i), address i>>1
    int ld_bank [8]  = '{0, 1, 1, 0, 1, 0, 0, 1};
    int ld_addr [8]  = '{0, 0, 1, 1, 2, 2, 3, 3};
    // Stage pairs, index s*4+j: s0 (0,4)(1,5)(2,6)(3,7); s1 (0,2)(1,3)(4,6)(5,7); s2 (0,1)..(6,7)
    int rd_a0 [12]   = '{0, 2, 3, 1,  0, 1, 3, 2,  0, 1, 2, 3};
    int rd_a1 [12]   = '{2, 0, 1, 3,  1, 0, 2, 3,  0, 1, 2, 3};
    int rd_fl [12]   = '{0, 1, 1, 0,  0, 1, 1, 0,  0, 1, 1, 0};
    // Unload k -> i=bitrev(k): 0,4,2,6,1,5,3,7
    int unl_bank [8] = '{0, 1, 1, 0, 1, 0, 0, 1};
    int unl_addr [8] = '{0, 2, 1, 3, 0, 2, 1, 3};

    task automatic chk(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic ev_t mk(input int t, input int bank, input int a0,
                               input int a1, input int flag, input int stg);
        ev_t e;
        e.t = t; e.bank = bank; e.a0 = a0; e.a1 = a1; e.flag = flag; e.stg = stg;
        return e;
    endfunction

    // Expected frame for N=8, WLAT=2: LOAD 0..7, stage s reads at 8+6s+j,
    // write-back 2 later, unload reads 26..33, out_valid 27..34, done at 34
    task automatic push_frame_a();
        for (int k = 0; k < 8; k++)
            q_ld.push_back(mk(k, ld_bank[k], ld_addr[k], 0, 0, 0));
        for (int s = 0; s < 3; s++) begin
            for (int j = 0; j < 4; j++) begin
                q_rd.push_back(mk(8 + 6*s + j, 0, rd_a0[s*4+j], rd_a1[s*4+j], rd_fl[s*4+j], s));
                q_wb.push_back(mk(10 + 6*s + j, 0, rd_a0[s*4+j], rd_a1[s*4+j], rd_fl[s*4+j], s));
            end
        end
        for (int k = 0; k < 8; k++) begin
            q_unl.push_back(mk(26 + k, unl_bank[k], unl_addr[k], 0, 0, 0));
            q_out.push_back(mk(27 + k, unl_bank[k], 0, 0, (k == 7) ? 1 : 0, 0));
        end
    endtask

    // Monitor A
    int  rel_a = -1000;
    int  cur_a;
    int  pend_a = 0;
    int  exp_sw_a = 0;
    ev_t ea;
    always @(negedge clk) begin
        if (!nrst) begin
            rel_a  = -1000;
            pend_a = 0;
        end else if (!valid_a) begin
            chk("a_bubble_we_re", int'({we_b0_a, we_b1_a, re_b0_a, re_b1_a}), 0);
        end else begin
            cur_a = rel_a;
            if (pend_a != 0) begin
                chk("a_swap0", int'(swap0_en_a), exp_sw_a);
                pend_a = 0;
            end
            if (we_b0_a ^ we_b1_a) begin
                if (q_ld.size() == 0) chk("a_load_unexpected", 1, 0);
                else begin
                    ea = q_ld.pop_front();
                    chk("a_load_t", cur_a, ea.t);
                    chk("a_load_bank", int'(we_b1_a), ea.bank);
                    chk("a_load_addr", int'(we_b1_a ? waddr_b1_a : waddr_b0_a), ea.a0);
                    chk("a_load_input_done", int'(input_done_a), 0);
                end
            end
            if (we_b0_a & we_b1_a) begin
                if (q_wb.size() == 0) chk("a_wb_unexpected", 1, 0);
                else begin
                    ea = q_wb.pop_front();
                    chk("a_wb_t", cur_a, ea.t);
                    chk("a_wb_waddr0", int'(waddr_b0_a), ea.a0);
                    chk("a_wb_waddr1", int'(waddr_b1_a), ea.a1);
                    chk("a_wb_swap1", int'(swap1_en_a), ea.flag);
                end
            end
            if (re_b0_a & re_b1_a) begin
                if (q_rd.size() == 0) chk("a_rd_unexpected", 1, 0);
                else begin
                    ea = q_rd.pop_front();
                    chk("a_rd_t", cur_a, ea.t);
                    chk("a_rd_raddr0", int'(raddr_b0_a), ea.a0);
                    chk("a_rd_raddr1", int'(raddr_b1_a), ea.a1);
                    chk("a_rd_stage", int'(stage_a), ea.stg);
                    chk("a_rd_input_done", int'(input_done_a), 1);
                    pend_a   = 1;
                    exp_sw_a = ea.flag;
                end
            end
            if (re_b0_a ^ re_b1_a) begin
                if (q_unl.size() == 0) chk("a_unl_unexpected", 1, 0);
                else begin
                    ea = q_unl.pop_front();
                    chk("a_unl_t", cur_a, ea.t);
                    chk("a_unl_bank", int'(re_b1_a), ea.bank);
                    chk("a_unl_addr", int'(re_b1_a ? raddr_b1_a : raddr_b0_a), ea.a0);
                end
            end
            if (out_valid_a) begin
                if (q_out.size() == 0) chk("a_out_unexpected", 1, 0);
                else begin
                    ea = q_out.pop_front();
                    chk("a_out_t", cur_a, ea.t);
                    chk("a_out_bank", int'(out_bank_a), ea.bank);
                    chk("a_done", int'(done_a), ea.flag);
                    chk("a_out_busy", int'(busy_a), 1);
                end
            end else if (done_a) begin
                chk("a_done_without_out_valid", 1, 0);
            end
            if (start_a && (rel_a < 0 || rel_a >= 35)) rel_a = 0;
            else rel_a++;
        end
    end

    // Monitor B: pair structure, write-back latency, frame length
    int  rel_b = -1000;
    int  cur_b;
    int  n_rd_b = 0, n_wb_b = 0, n_out_b = 0, t_done_b = -1, max_stg_b = 0;
    logic [5:0] i0_b, i1_b;
    ev_t eb;
    always @(negedge clk) begin
        if (!nrst) begin
            rel_b = -1000;
        end else if (valid_b) begin
            cur_b = rel_b;
            if (re_b0_b & re_b1_b) begin
                n_rd_b++;
                if (int'(stage_b) > max_stg_b) max_stg_b = int'(stage_b);
                i0_b = {raddr_b0_b, ^raddr_b0_b};
                i1_b = {raddr_b1_b, ~^raddr_b1_b};
                chk("b_pair_partner", int'(i0_b ^ i1_b), 1 << (5 - int'(stage_b)));
                q_wb_b.push_back(mk(cur_b + 4, 0, int'(raddr_b0_b), int'(raddr_b1_b), int'(swap0_en_b), 0));
            end
            if (we_b0_b & we_b1_b) begin
                n_wb_b++;
                if (q_wb_b.size() == 0) chk("b_wb_unexpected", 1, 0);
                else begin
                    eb = q_wb_b.pop_front();
                    chk("b_wb_t", cur_b, eb.t);
                    chk("b_wb_waddr0", int'(waddr_b0_b), eb.a0);
                    chk("b_wb_waddr1", int'(waddr_b1_b), eb.a1);
                end
            end
            if (out_valid_b) n_out_b++;
            if (done_b) t_done_b = cur_b;
            if (start_b && (rel_b < 0 || rel_b >= 345)) rel_b = 0;
            else rel_b++;
        end
    end

    task automatic cyc_a(input logic st, input logic v);
        start_a = st;
        valid_a = v;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_b(input logic st, input logic v);
        start_b = st;
        valid_b = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 1'b0;
        start_a = 1'b0; valid_a = 1'b0;
        start_b = 1'b0; valid_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("a_reset_outputs", int'({busy_a, input_done_a, stage_a, swap0_en_a, swap1_en_a,
            we_b0_a, re_b0_a, we_b1_a, re_b1_a, waddr_b0_a, raddr_b0_a, waddr_b1_a,
            raddr_b1_a, out_valid_a, out_bank_a, done_a}), 0);
        nrst = 1'b1;
        cyc_a(0, 1);
        cyc_a(0, 1);

        // Continuous frame; a stray start mid-LOAD must be ignored
        push_frame_a();
        cyc_a(1, 1);
        for (int r = 0; r < 40; r++) cyc_a(r == 3, 1);

        // Same frame with valid toggling every cycle
        push_frame_a();
        cyc_a(1, 1);
        for (int r = 0; r < 80; r++) cyc_a(0, (r % 2) == 1);

        // Abort during stage 1, then a clean frame
        push_frame_a();
        cyc_a(1, 1);
        repeat (16) cyc_a(0, 1);
        chk("a_stage_before_abort", int'(stage_a), 1);
        nrst = 1'b0;
        #1;
        chk("a_abort_outputs", int'({busy_a, input_done_a, stage_a, swap0_en_a, swap1_en_a,
            we_b0_a, re_b0_a, we_b1_a, re_b1_a, waddr_b0_a, raddr_b0_a, waddr_b1_a,
            raddr_b1_a, out_valid_a, out_bank_a, done_a}), 0);
        q_ld.delete(); q_rd.delete(); q_wb.delete(); q_unl.delete(); q_out.delete();
        cyc_a(0, 1);
        cyc_a(0, 1);
        nrst = 1'b1;
        cyc_a(0, 1);
        push_frame_a();
        cyc_a(1, 1);
        for (int r = 0; r < 40; r++) cyc_a(0, 1);
        cyc_a(0, 0);
        chk("a_queues_drained", q_ld.size() + q_rd.size() + q_wb.size() + q_unl.size() + q_out.size(), 0);
        chk("a_idle_after_frames", int'(busy_a), 0);

        // Large configuration: 64 points, WLAT=4
        cyc_b(1, 1);
        for (int r = 0; r < 360; r++) cyc_b(0, 1);
        cyc_b(0, 0);
        chk("b_done_cycle", t_done_b, 344);
        chk("b_stage_reads", n_rd_b, 192);
        chk("b_writebacks", n_wb_b, 192);
        chk("b_out_valid_count", n_out_b, 64);
        chk("b_max_stage", max_stg_b, 5);
        chk("b_wb_queue_drained", q_wb_b.size(), 0);
        chk("b_idle_after_frame", int'(busy_b), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
